// File: rtl/gaussian_blur_3x3.sv
// gaussian_blur_3x3: streaming 3x3 Gaussian smoothing of an N x M grayscale
// frame. Pixels arrive in raster order one per GS_valid strobe; the interior
// (N-2) x (M-2) blurred pixels leave in raster order one cycle after the pixel
// that completes their window. A done pulse follows the final output.
module gaussian_blur_3x3 #(
  parameter int N = 450,
  parameter int M = 450
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       GB_enable,
  input  logic       GS_valid,
  input  logic [7:0] Din,
  output logic [7:0] Dout,
  output logic       GB_valid,
  output logic       GB_busy,
  output logic       GB_done
);

  localparam int CW = $clog2(N);
  localparam int RW = $clog2(M);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  // Window indexed [column][row]: column 0 is the oldest (leftmost),
  // row 0 is the oldest line (r-2), row 2 is the incoming line (r).
  logic [2:0][2:0][7:0] win_q, win_d;
  logic [7:0]          dout_q, dout_d;
  logic                vld_q, vld_d;
  logic                accept;
  logic [11:0]         sum;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2, both indexed by column.
  logic [7:0] lb1 [N];
  logic [7:0] lb2 [N];

  // Next-state logic: frame sequencing, raster counters and window shift.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        if (GB_enable) state_d = RUN;
      end
      RUN: begin
        if (GS_valid) begin
          accept      = 1'b1;
          win_d[0]    = win_q[1];
          win_d[1]    = win_q[2];
          win_d[2][0] = lb2[col_q];
          win_d[2][1] = lb1[col_q];
          win_d[2][2] = Din;
          if (col_q == CW'(N-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == RW'(M-1)) state_d = FLUSH;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Kernel [1 2 1; 2 4 2; 1 2 1] on the window as it stands after this pixel;
  // a result is produced only when all three columns lie in rows >= 0 of this line.
  always_comb begin
    sum = {4'd0, win_d[0][0]} + {3'd0, win_d[0][1], 1'b0} + {4'd0, win_d[0][2]}
        + {3'd0, win_d[1][0], 1'b0} + {2'd0, win_d[1][1], 2'b0} + {3'd0, win_d[1][2], 1'b0}
        + {4'd0, win_d[2][0]} + {3'd0, win_d[2][1], 1'b0} + {4'd0, win_d[2][2]};
    vld_d  = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
    dout_d = vld_d ? sum[11:4] : 8'h00;
  end

  // State, counters, window and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  // Line buffer update; contents need no reset since every window is
  // refilled from the current frame before it is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_q] <= lb1[col_q];
      lb1[col_q] <= Din;
    end
  end

  assign Dout     = dout_q;
  assign GB_valid = vld_q;
  assign GB_busy  = (state_q == RUN) || (state_q == FLUSH);
  assign GB_done  = (state_q == DONE);

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Bench for gaussian_blur_3x3: three instances (4x4, 3x3, 5x4) share data
// inputs but have separate enables. A per-cycle expectation schedule is built
// from a plain 2D convolution of the driven image and checked every cycle.
module tb_gaussian_blur_3x3;

  localparam int CMAX = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gs_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] en = 3'b000;
  logic [7:0] dout_w [3];
  logic [2:0] gv, busy, done;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int vcnt [3];
  int dcnt [3];

  bit [7:0] e_dout [3][CMAX];
  bit       e_vld  [3][CMAX];
  bit       e_busy [3][CMAX];
  bit       e_done [3][CMAX];

  int img [8][8];
  int acc [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gaussian_blur_3x3 #(.N(4), .M(4)) u0 (
    .clk(clk), .rst(rst), .GB_enable(en[0]), .GS_valid(gs_valid), .Din(din),
    .Dout(dout_w[0]), .GB_valid(gv[0]), .GB_busy(busy[0]), .GB_done(done[0]));
  gaussian_blur_3x3 #(.N(3), .M(3)) u1 (
    .clk(clk), .rst(rst), .GB_enable(en[1]), .GS_valid(gs_valid), .Din(din),
    .Dout(dout_w[1]), .GB_valid(gv[1]), .GB_busy(busy[1]), .GB_done(done[1]));
  gaussian_blur_3x3 #(.N(5), .M(4)) u2 (
    .clk(clk), .rst(rst), .GB_enable(en[2]), .GS_valid(gs_valid), .Din(din),
    .Dout(dout_w[2]), .GB_valid(gv[2]), .GB_busy(busy[2]), .GB_done(done[2]));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference blur: weighted neighbourhood sum, weights 2 on the centre
  // row/column and 1 off it, divided by 16 with truncation.
  function automatic int blur(input int r, input int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += img[r+dr][c+dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
    return s / 16;
  endfunction

  // Per-cycle check of every instance against the schedule.
  always @(negedge clk) begin
    if (cyc < CMAX) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("u%0d GB_valid", d), int'(gv[d]),    int'(e_vld[d][cyc]));
        chk($sformatf("u%0d Dout", d),     int'(dout_w[d]), int'(e_dout[d][cyc]));
        chk($sformatf("u%0d GB_busy", d),  int'(busy[d]),  int'(e_busy[d][cyc]));
        chk($sformatf("u%0d GB_done", d),  int'(done[d]),  int'(e_done[d][cyc]));
        if (gv[d])   vcnt[d]++;
        if (done[d]) dcnt[d]++;
      end
    end
  end

  // Enable instance d, then feed the first lim pixels of the w x h image in img
  // with random gaps up to maxgap. pre: IDLE strobes before enable; extra:
  // strobes straight after the last pixel (both must be ignored).
  task automatic run_frame(input int d, input int w, input int h, input int lim,
                           input int maxgap, input int pre, input int extra);
    int e, t, i;
    for (int k = 0; k < pre; k++) begin
      @(posedge clk); #1;
      gs_valid = 1'b1; din = 8'($urandom);
    end
    @(posedge clk); #1;
    en[d] = 1'b1; gs_valid = 1'b1; din = 8'd77;
    e = cyc;
    t = e + 1;
    for (int k = 0; k < lim; k++) begin
      t += int'($urandom_range(0, maxgap));
      acc[k] = t;
      t++;
    end
    for (int k = e + 1; k < ((lim == w*h) ? acc[lim-1] + 2 : CMAX); k++) e_busy[d][k] = 1'b1;
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++)
        if (r*w + c < lim) begin
          e_vld[d][acc[r*w+c] + 1]  = 1'b1;
          e_dout[d][acc[r*w+c] + 1] = 8'(blur(r-1, c-1));
        end
    if (lim == w*h) e_done[d][acc[lim-1] + 2] = 1'b1;
    i = 0;
    while (i < lim) begin
      @(posedge clk); #1;
      en[d] = 1'b0;
      if (cyc == acc[i]) begin
        gs_valid = 1'b1; din = 8'(img[i/w][i%w]); i++;
      end else begin
        gs_valid = 1'b0; din = 8'($urandom);
      end
    end
    for (int k = 0; k < extra; k++) begin
      @(posedge clk); #1;
      gs_valid = 1'b1; din = 8'($urandom);
    end
    @(posedge clk); #1;
    gs_valid = 1'b0; din = 8'h00;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    int x;
    @(posedge clk); #1;
    rst = 1'b1;
    x = cyc;
    for (int d = 0; d < 3; d++)
      for (int k = x; k < CMAX; k++) begin
        e_vld[d][k] = 1'b0; e_dout[d][k] = 8'h00; e_busy[d][k] = 1'b0; e_done[d][k] = 1'b0;
      end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = v;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin vcnt[d] = 0; dcnt[d] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 4x4 constant 100
    fill(100);
    chk("pin const100", blur(1, 1), 100);
    run_frame(0, 4, 4, 16, 0, 0, 0);

    // 3x3 impulse, all-255, corner
    fill(0); img[1][1] = 255;
    chk("pin impulse", blur(1, 1), 63);
    run_frame(1, 3, 3, 9, 0, 0, 0);
    fill(255);
    chk("pin all255", blur(1, 1), 255);
    run_frame(1, 3, 3, 9, 0, 0, 0);
    fill(0); img[0][0] = 255;
    chk("pin corner", blur(1, 1), 15);
    run_frame(1, 3, 3, 9, 0, 0, 0);

    // 4x4 horizontal ramp with gaps
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 16 * c;
    chk("pin ramp c1", blur(1, 1), 16);
    chk("pin ramp c2", blur(2, 2), 32);
    run_frame(0, 4, 4, 16, 5, 0, 0);

    // 5x4 sequential values with IDLE strobes before and extra strobes after
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) img[r][c] = 5 * r + c;
    chk("pin seq", blur(1, 1), 6);
    chk("pin seq2", blur(2, 3), 13);
    run_frame(2, 5, 4, 20, 0, 3, 3);

    // reset after 10 of 16 pixels, then constant 50 frame
    fill(50);
    run_frame(0, 4, 4, 10, 0, 0, 0);
    do_reset();
    run_frame(0, 4, 4, 16, 0, 0, 0);

    // 5x4 random pixels with gaps
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame(2, 5, 4, 20, 3, 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("u0 output count", vcnt[0], 12);
    chk("u1 output count", vcnt[1], 3);
    chk("u2 output count", vcnt[2], 12);
    chk("u0 done count", dcnt[0], 3);
    chk("u1 done count", dcnt[1], 3);
    chk("u2 done count", dcnt[2], 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gaussian_blur_3x3.md
Name: gaussian_blur_3x3

Overview:
Streaming 3x3 Gaussian smoothing stage directly downstream of the grayscale converter. It consumes one grayscale byte per valid strobe, in raster order, for an N x M frame. It emits the (N-2) x (M-2) interior blurred pixels, also in raster order, towards the second memory module. Completion is reported to the controller through a done pulse.

Parameters:
N, 450, frame width in pixels (min 3)
M, 450, frame height in pixels (min 3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
GB_enable  input  1  start request from controller, sampled in IDLE only
GS_valid  input  1  one-cycle strobe: Din holds a grayscale pixel
Din  input  8  grayscale pixel from converter
Dout  output  8  blurred pixel, 8'h00 when GB_valid low
GB_valid  output  1  one-cycle strobe: Dout holds a blurred pixel
GB_busy  output  1  high in RUN and FLUSH
GB_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst=1): state=IDLE; Dout=0, GB_valid=0, GB_busy=0, GB_done=0; column and row counters=0; window registers=0. Line-buffer contents are don't-care.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on GB_enable=1. GS_valid/Din in IDLE are ignored, including in the cycle GB_enable is seen.
  - RUN: each GS_valid=1 cycle accepts Din at (row r, col c). Counters advance c=0..N-1, then wrap to c=0 and r+1. Idle cycles (GS_valid=0) hold all state; arbitrary gaps are legal.
  - RUN -> FLUSH on acceptance of pixel (M-1, N-1).
  - FLUSH lasts 1 cycle and drives the final output.
  - FLUSH -> DONE, DONE -> IDLE unconditionally.
  - GB_done=1 exactly during DONE (1 cycle).
- No backpressure: the block must accept a pixel on every GS_valid cycle in RUN. GS_valid in FLUSH/DONE is ignored; extra pixels are dropped.
- GB_enable in RUN/FLUSH/DONE is ignored. A new frame needs a fresh GB_enable in IDLE.
- Line buffers: two N x 8 buffers indexed by c, holding rows r-1 and r-2.
  - On acceptance, the column c entries shift: row r-2 takes the old row r-1 value, row r-1 takes Din.
  - The 3x3 window (3 columns x 3 rows) shifts left by one column. The new right column is {buf2[c], buf1[c], Din}.
- Output condition: an accepted pixel with r>=2 and c>=2 completes the window centred at (r-1, c-1).
  - The result is registered: GB_valid=1 and Dout valid in the cycle after acceptance (latency 1).
  - Otherwise GB_valid=0 and Dout=0.
  - Windows never span a row wrap, because c>=2 guarantees all three columns are in the current row.
- Arithmetic, kernel [1 2 1; 2 4 2; 1 2 1]:
  - Sum computed at 12 bits unsigned (max 4080).
  - Dout = sum[11:4], i.e. truncate, no rounding; saturation is impossible.
- Output count per frame: exactly (N-2)*(M-2) GB_valid pulses. The last one falls in the FLUSH cycle, and GB_done follows it in the next cycle.
- Reset mid-frame: immediate return to IDLE, outputs cleared, partial frame discarded. The next frame needs GB_enable.

Test Plan:
- N=M=4, GB_enable then 16 pixels all 100 back-to-back -> 4 GB_valid pulses, Dout=100 each, each 1 cycle after pixels (2,2),(2,3),(3,2),(3,3). GB_done pulses 2 cycles after the last input; GB_busy low afterwards.
- N=M=3, impulse 255 at (1,1), others 0 -> single output Dout=63 (1020>>4). All 255 -> Dout=255. Pixel 255 only at corner (0,0) -> Dout=15.
- N=M=4, horizontal ramp Din=16*c, random 0-5 cycle gaps between GS_valid -> outputs 16,32,16,32; no output during gaps; latency is always 1 cycle after the completing pixel.
- N=5,M=4, GS_valid pulsed in IDLE before GB_enable and 3 extra pixels after the frame -> those pixels are ignored. Exactly 6 outputs match a software model of a frame of sequential values; GB_done once.
- Assert rst for 1 cycle after 10 of 16 pixels (N=M=4) -> GB_valid/GB_busy drop immediately, state IDLE. A new GB_enable plus a full constant-50 frame -> 4 outputs of 50.
- N=M=450 default, random pixels -> 448*448=200704 outputs match the reference model bit-exactly, and GB_done is asserted exactly once.
